// File: rtl/outport_credit_reg_pkg.sv
// outport_credit_reg_pkg: shared sizes, flit field positions, log2 helper and ownership encoding
package outport_credit_reg_pkg;
    localparam int V  = 4;
    localparam int P  = 5;
    localparam int Fw = 36;
    localparam int B  = 4;
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
    localparam int Bw       = log2(B + 1);
    localparam int HDR_BIT  = Fw - 1;
    localparam int TAIL_BIT = Fw - 2;
    localparam int VC_MSB   = Fw - 3;
    localparam int VC_LSB   = Fw - 2 - V;
    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} own_t;
endpackage

// File: rtl/outport_credit_reg_if.sv
// outport_credit_reg_if: crossbar-side flits/strobes/credits in, link flits and per-VC status out
//   slave  : the register stage (receives flits and credits, drives link outputs and status)
//   master : the environment (crossbar, downstream credit return, allocators)
interface outport_credit_reg_if;
    import outport_credit_reg_pkg::*;
    logic [P*Fw-1:0] flit_in_all;
    logic [P-1:0]    flit_in_wr_all;
    logic [P*V-1:0]  credit_in_all;
    logic [P*Fw-1:0] flit_out_all;
    logic [P-1:0]    flit_out_wr_all;
    logic [P*V-1:0]  ovc_full_all;
    logic [P*V-1:0]  ovc_nearly_full_all;
    logic [P*V-1:0]  ovc_owned_all;
    logic [P*V-1:0]  credit_err_all;
    modport slave (
        input  flit_in_all, flit_in_wr_all, credit_in_all,
        output flit_out_all, flit_out_wr_all, ovc_full_all, ovc_nearly_full_all, ovc_owned_all, credit_err_all
    );
    modport master (
        output flit_in_all, flit_in_wr_all, credit_in_all,
        input  flit_out_all, flit_out_wr_all, ovc_full_all, ovc_nearly_full_all, ovc_owned_all, credit_err_all
    );
endinterface

// File: rtl/outport_vc_credit_cnt.sv
// outport_vc_credit_cnt: one output VC's credit counter, ownership FSM and sticky error flag
//   in : clk, reset, wr (strobe & VC bit), bad (VC field not one-hot), credit, hdr, tail
//   out: full (count==0), nearly_full (count==1), owned, err
module outport_vc_credit_cnt
    import outport_credit_reg_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic wr,
    input  logic bad,
    input  logic credit,
    input  logic hdr,
    input  logic tail,
    output logic full,
    output logic nearly_full,
    output logic owned,
    output logic err
);
    logic [Bw-1:0] cnt;
    own_t st;
    logic ok, dec, inc, under, over, proto;
    // a malformed VC field flags an error but never moves the counter or FSM
    always_comb begin
        ok    = wr & ~bad;
        dec   = ok & ~credit;
        inc   = credit & ~ok;
        under = dec && cnt == '0;
        over  = inc && cnt == Bw'(B);
        proto = ok && (st == IDLE ? ~hdr : hdr);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= Bw'(B);
            st  <= IDLE;
            err <= 1'b0;
        end else begin
            cnt <= (under || over) ? cnt : dec ? cnt - 1'b1 : inc ? cnt + 1'b1 : cnt;
            if (ok) st <= st == IDLE ? ((hdr & ~tail) ? OWNED : IDLE) : ((tail & ~hdr) ? IDLE : OWNED);
            err <= err | (wr & bad) | under | over | proto;
        end
    end
    assign full        = cnt == '0;
    assign nearly_full = cnt == Bw'(1);
    assign owned       = st == OWNED;
endmodule

// File: rtl/outport_credit_reg.sv
// outport_credit_reg: registers crossbar output flits/strobes and tracks per-VC credits and ownership
//   in : clk, reset, bus.slave (flit_in_all, flit_in_wr_all, credit_in_all)
//   out: bus.slave (flit_out_all, flit_out_wr_all, ovc_full/nearly_full/owned_all, credit_err_all)
module outport_credit_reg
    import outport_credit_reg_pkg::*;
(
    input logic clk,
    input logic reset,
    outport_credit_reg_if.slave bus
);
    logic [P*Fw-1:0] flit_q;
    logic [P-1:0]    wr_q;
    logic [P*V-1:0]  full, nearly_full, owned, err;
    always_ff @(posedge clk) begin
        if (reset) begin
            flit_q <= '0;
            wr_q   <= '0;
        end else begin
            wr_q <= bus.flit_in_wr_all;
            for (int i = 0; i < P; i++)
                if (bus.flit_in_wr_all[i]) flit_q[i*Fw +: Fw] <= bus.flit_in_all[i*Fw +: Fw];
        end
    end
    for (genvar i = 0; i < P; i++) begin : g_p
        logic [V-1:0] vc;
        logic bad;
        always_comb begin
            vc  = bus.flit_in_all[i*Fw+VC_LSB +: V];
            bad = ~$onehot(vc);
        end
        for (genvar v = 0; v < V; v++) begin : g_v
            outport_vc_credit_cnt u_cnt (
                .clk         (clk),
                .reset       (reset),
                .wr          (bus.flit_in_wr_all[i] & vc[v]),
                .bad         (bad),
                .credit      (bus.credit_in_all[i*V+v]),
                .hdr         (bus.flit_in_all[i*Fw+HDR_BIT]),
                .tail        (bus.flit_in_all[i*Fw+TAIL_BIT]),
                .full        (full[i*V+v]),
                .nearly_full (nearly_full[i*V+v]),
                .owned       (owned[i*V+v]),
                .err         (err[i*V+v])
            );
        end
    end
    assign bus.flit_out_all        = flit_q;
    assign bus.flit_out_wr_all     = wr_q;
    assign bus.ovc_full_all        = full;
    assign bus.ovc_nearly_full_all = nearly_full;
    assign bus.ovc_owned_all       = owned;
    assign bus.credit_err_all      = err;
endmodule
